// File: rtl/noc_ni_pkg.sv
// NoC network interface: shared constants, packet layout
// and TX link FSM state encoding.
package noc_ni_pkg;

    localparam int PAYLOAD = 4;
    localparam int X_BITS  = 1;
    localparam int Y_BITS  = 1;
    localparam int PKT_W   = X_BITS + Y_BITS + PAYLOAD;

    typedef struct packed {
        logic [X_BITS-1:0]  x;
        logic [Y_BITS-1:0]  y;
        logic [PAYLOAD-1:0] payload;
    } packet_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT
    } ni_tx_state_e;

endpackage

// File: rtl/noc_ni_if.sv
// NoC network interface: PE-side valid/ready stream bundle.
// master = processing element, slave = network interface.
interface noc_ni_if
    import noc_ni_pkg::*;
#(
    parameter int DATA_W = PKT_W
);

    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] rx_data;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready,
        input  rx_valid,
        input  rx_data,
        output rx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        output rx_valid,
        output rx_data,
        input  rx_ready
    );

endinterface

// File: rtl/noc_ni_sync_fifo.sv
// NoC network interface: single-clock FIFO with occupancy.
// A push into a full FIFO is taken only if a pop happens on the same edge.
module noc_ni_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // storage, pointers and occupancy; cleared so the head reads 0 after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/noc_ni.sv
// NoC network interface: PE valid/ready stream <-> 2-phase toggle
// req/ack mesh link, with TX/RX buffering, misroute flag and counters.
module noc_ni
    import noc_ni_pkg::*;
#(
    parameter int PAYLOAD     = noc_ni_pkg::PAYLOAD,
    parameter int X_BITS      = noc_ni_pkg::X_BITS,
    parameter int Y_BITS      = noc_ni_pkg::Y_BITS,
    parameter int MY_X        = 0,
    parameter int MY_Y        = 0,
    parameter int TX_DEPTH    = 4,
    parameter int RX_DEPTH    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    localparam int W          = X_BITS + Y_BITS + PAYLOAD,
    localparam int HDR_W      = X_BITS + Y_BITS,
    localparam int TXL_W      = $clog2(TX_DEPTH) + 1,
    localparam int RXL_W      = $clog2(RX_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    noc_ni_if.slave          pe,
    output logic             req_o,
    output logic [W-1:0]     data_o,
    input  logic             ack_i,
    input  logic             req_i,
    input  logic [W-1:0]     data_i,
    output logic             ack_o,
    output logic [TXL_W-1:0] tx_level_o,
    output logic [RXL_W-1:0] rx_level_o,
    output logic             rx_misroute_o,
    output logic [CNT_W-1:0] tx_sent_o,
    output logic [CNT_W-1:0] rx_recv_o
);

    localparam logic [HDR_W-1:0] MY_HDR =
        {X_BITS'(MY_X), Y_BITS'(MY_Y)};

    logic [SYNC_STAGES-1:0] req_ff;
    logic [SYNC_STAGES-1:0] ack_ff;
    logic                   req_sync;
    logic                   ack_sync;
    logic                   req_seen;
    logic                   ack_seen;

    ni_tx_state_e           state;
    ni_tx_state_e           state_n;
    logic                   tx_load;
    logic                   tx_toggle;
    logic                   tx_pop;
    logic                   tx_push;
    logic                   tx_full;
    logic                   tx_empty;
    logic                   tx_rdy;
    logic [W-1:0]           tx_head;

    logic                   rx_pop;
    logic                   rx_accept;
    logic                   rx_full;
    logic                   rx_empty;

    assign req_sync = req_ff[SYNC_STAGES-1];
    assign ack_sync = ack_ff[SYNC_STAGES-1];

    // incoming toggles cross from the router's timing domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ff <= '0;
            ack_ff <= '0;
        end else begin
            req_ff <= {req_ff[SYNC_STAGES-2:0], req_i};
            ack_ff <= {ack_ff[SYNC_STAGES-2:0], ack_i};
        end
    end

    // ---------------- TX path ----------------
    assign tx_rdy      = ~tx_full & ~rst;
    assign pe.tx_ready = tx_rdy;
    assign tx_push     = pe.tx_valid & tx_rdy;

    noc_ni_sync_fifo #(
        .WIDTH (W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (pe.tx_data),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level_o)
    );

    // TX FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // TX FSM: present data, then toggle req, then wait for the ack toggle
    always_comb begin
        state_n   = state;
        tx_load   = 1'b0;
        tx_toggle = 1'b0;
        tx_pop    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!tx_empty) begin
                    tx_load = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                tx_toggle = 1'b1;
                state_n   = WAIT;
            end
            WAIT: begin
                if (ack_sync != ack_seen) begin
                    tx_pop  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // link TX datapath: data leads req by one edge and holds until ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_o    <= '0;
            req_o     <= 1'b0;
            ack_seen  <= 1'b0;
            tx_sent_o <= '0;
        end else begin
            if (tx_load) begin
                data_o <= tx_head;
            end
            if (tx_toggle) begin
                req_o <= ~req_o;
            end
            if (tx_pop) begin
                ack_seen  <= ack_sync;
                tx_sent_o <= tx_sent_o + CNT_W'(1);
            end
        end
    end

    // ---------------- RX path ----------------
    assign rx_pop      = ~rx_empty & pe.rx_ready;
    assign rx_accept   = (req_sync != req_seen) & (~rx_full | rx_pop);
    assign pe.rx_valid = ~rx_empty;

    noc_ni_sync_fifo #(
        .WIDTH (W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_accept),
        .pop   (rx_pop),
        .din   (data_i),
        .dout  (pe.rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level_o)
    );

    // link RX handshake: ack only once the packet is stored (back-pressure)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_seen      <= 1'b0;
            ack_o         <= 1'b0;
            rx_recv_o     <= '0;
            rx_misroute_o <= 1'b0;
        end else if (rx_accept) begin
            req_seen  <= req_sync;
            ack_o     <= ~ack_o;
            rx_recv_o <= rx_recv_o + CNT_W'(1);
            if (data_i[W-1 -: HDR_W] != MY_HDR) begin
                rx_misroute_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_ni.sv
// Bench for noc_ni: directed link scenarios plus randomized
// concurrent TX/RX traffic checked against queue-based models.
module tb_noc_ni;
    import noc_ni_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_o;
    logic [5:0]  data_o;
    logic        ack_i;
    logic        req_i;
    logic [5:0]  data_i;
    logic        ack_o;
    logic [2:0]  tx_level_o;
    logic [2:0]  rx_level_o;
    logic        rx_misroute_o;
    logic [15:0] tx_sent_o;
    logic [15:0] rx_recv_o;

    int          n_vec = 0;
    int          n_bad = 0;
    logic        req_ph;
    logic        ack_ph;
    logic [5:0]  tx_q[$];
    logic [5:0]  rx_q[$];
    bit          exp_mis;

    noc_ni_if #(.DATA_W(6)) pe ();

    noc_ni #(
        .MY_X (0),
        .MY_Y (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pe            (pe.slave),
        .req_o         (req_o),
        .data_o        (data_o),
        .ack_i         (ack_i),
        .req_i         (req_i),
        .data_i        (data_i),
        .ack_o         (ack_o),
        .tx_level_o    (tx_level_o),
        .rx_level_o    (rx_level_o),
        .rx_misroute_o (rx_misroute_o),
        .tx_sent_o     (tx_sent_o),
        .rx_recv_o     (rx_recv_o)
    );

    // free-running clock
    always #5 clk = ~clk;

    // hard stop in case something wedges outside a bounded wait
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // router side of the TX link: wait for req toggle, check data, ack it
    task automatic tx_serve(input int dly, output bit to);
        logic [5:0] exp;
        int k = 0;
        while (req_o === req_ph && k < 200) begin
            tick(1);
            k++;
        end
        to = (req_o === req_ph);
        check("tx_req_timeout", 32'(to), 32'(0));
        if (!to) begin
            exp = (tx_q.size() != 0) ? tx_q.pop_front() : 6'h3f;
            check("tx_data", 32'(data_o), 32'(exp));
            req_ph = !req_ph;
            if (dly > 0) tick(dly);
            ack_i = !ack_i;
        end
    endtask

    // router side of the RX link: present data, toggle req, wait for ack
    task automatic rx_send(input logic [5:0] d, input int bound,
                           output bit acked);
        data_i = d;
        req_i  = !req_i;
        acked  = 1'b0;
        for (int k = 0; k < bound && !acked; k++) begin
            tick(1);
            if (ack_o !== ack_ph) begin
                acked  = 1'b1;
                ack_ph = !ack_ph;
            end
        end
    endtask

    // PE side: pop one RX packet and compare with the model order
    task automatic rx_pop_check(input string tag);
        logic [5:0] exp;
        exp = (rx_q.size() != 0) ? rx_q.pop_front() : 6'h3f;
        check({tag, "_valid"}, 32'(pe.rx_valid), 32'(1));
        check({tag, "_data"}, 32'(pe.rx_data), 32'(exp));
        pe.rx_ready = 1'b1;
        tick(1);
        pe.rx_ready = 1'b0;
    endtask

    task automatic pe_tx_proc(input int n);
        int         sent = 0;
        int         guard = 0;
        logic [5:0] d;
        bit         acc;
        while (sent < n && guard < 5000) begin
            d = 6'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                pe.tx_valid = 1'b1;
                pe.tx_data  = d;
                acc         = pe.tx_ready;
            end else begin
                pe.tx_valid = 1'b0;
                acc         = 1'b0;
            end
            tick(1);
            if (acc) begin
                tx_q.push_back(d);
                sent++;
            end
            guard++;
        end
        pe.tx_valid = 1'b0;
        check("rnd_tx_pushed", 32'(sent), 32'(n));
    endtask

    task automatic link_tx_proc(input int n);
        bit to;
        for (int i = 0; i < n; i++) begin
            tx_serve($urandom_range(0, 3), to);
            if (to) break;
        end
    endtask

    task automatic link_rx_proc(input int n);
        packet_t p;
        bit      acked;
        for (int i = 0; i < n; i++) begin
            p.x       = 1'($urandom_range(0, 3) == 0);
            p.y       = 1'($urandom_range(0, 3) != 0);
            p.payload = 4'($urandom);
            if ({p.x, p.y} != 2'b01) exp_mis = 1'b1;
            rx_q.push_back(p);
            rx_send(p, 200, acked);
            check("rnd_rx_acked", 32'(acked), 32'(1));
            if (!acked) break;
            if ($urandom_range(0, 1) != 0) tick($urandom_range(1, 3));
        end
    endtask

    task automatic pe_rx_proc(input int n);
        int         got = 0;
        int         guard = 0;
        bit         r;
        logic [5:0] exp;
        while (got < n && guard < 8000) begin
            r = 1'($urandom_range(0, 1));
            pe.rx_ready = r;
            if (r && pe.rx_valid) begin
                exp = (rx_q.size() != 0) ? rx_q.pop_front() : 6'h3f;
                check("rnd_rx_data", 32'(pe.rx_data), 32'(exp));
                got++;
            end
            tick(1);
            guard++;
        end
        pe.rx_ready = 1'b0;
        check("rnd_rx_popped", 32'(got), 32'(n));
    endtask

    initial begin
        logic [5:0] pk;
        int         acc_n;
        bit         to;
        bit         acked;

        rst         = 1'b1;
        ack_i       = 1'b0;
        req_i       = 1'b0;
        data_i      = '0;
        pe.tx_valid = 1'b0;
        pe.tx_data  = '0;
        pe.rx_ready = 1'b0;
        req_ph      = 1'b0;
        ack_ph      = 1'b0;
        exp_mis     = 1'b0;

        // 1: reset state
        tick(2);
        check("rst_req_o", 32'(req_o), 32'(0));
        check("rst_ack_o", 32'(ack_o), 32'(0));
        check("rst_data_o", 32'(data_o), 32'(0));
        check("rst_rx_valid", 32'(pe.rx_valid), 32'(0));
        check("rst_rx_data", 32'(pe.rx_data), 32'(0));
        check("rst_tx_ready", 32'(pe.tx_ready), 32'(0));
        check("rst_tx_sent", 32'(tx_sent_o), 32'(0));
        check("rst_rx_recv", 32'(rx_recv_o), 32'(0));
        check("rst_misroute", 32'(rx_misroute_o), 32'(0));
        rst = 1'b0;
        #1;
        check("rel_tx_ready", 32'(pe.tx_ready), 32'(1));
        tick(1);

        // 2: single TX packet, exact latency
        pe.tx_valid = 1'b1;
        pe.tx_data  = 6'h25;
        tick(1);
        pe.tx_valid = 1'b0;
        check("t2_level_push", 32'(tx_level_o), 32'(1));
        check("t2_data_pre", 32'(data_o), 32'(0));
        tick(1);
        check("t2_data_p1", 32'(data_o), 32'(6'h25));
        check("t2_req_p1", 32'(req_o), 32'(0));
        tick(1);
        check("t2_req_p2", 32'(req_o), 32'(1));
        req_ph = 1'b1;
        ack_i  = 1'b1;
        tick(2);
        check("t2_level_inflight", 32'(tx_level_o), 32'(1));
        tick(1);
        check("t2_sent", 32'(tx_sent_o), 32'(1));
        check("t2_level_done", 32'(tx_level_o), 32'(0));

        // 3: ack frozen, five offers -> four accepted, drained in order
        acc_n       = 0;
        pe.tx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pk = 6'($urandom);
            pe.tx_data = pk;
            if (pe.tx_ready) begin
                tx_q.push_back(pk);
                acc_n++;
            end
            tick(1);
        end
        pe.tx_valid = 1'b0;
        check("t3_accepted", 32'(acc_n), 32'(4));
        check("t3_ready_full", 32'(pe.tx_ready), 32'(0));
        check("t3_level_full", 32'(tx_level_o), 32'(4));
        for (int i = 0; i < 4; i++) begin
            tx_serve(0, to);
        end
        tick(4);
        check("t3_sent", 32'(tx_sent_o), 32'(5));
        check("t3_level_done", 32'(tx_level_o), 32'(0));

        // 4: single RX packet, exact latency
        data_i = 6'h1A;
        req_i  = 1'b1;
        tick(2);
        check("t4_ack_early", 32'(ack_o), 32'(0));
        check("t4_valid_early", 32'(pe.rx_valid), 32'(0));
        tick(1);
        check("t4_ack", 32'(ack_o), 32'(1));
        check("t4_valid", 32'(pe.rx_valid), 32'(1));
        check("t4_data", 32'(pe.rx_data), 32'(6'h1A));
        check("t4_misroute", 32'(rx_misroute_o), 32'(0));
        ack_ph = 1'b1;
        pe.rx_ready = 1'b1;
        tick(1);
        pe.rx_ready = 1'b0;
        check("t4_valid_after_pop", 32'(pe.rx_valid), 32'(0));

        // 5: RX back-pressure, fifth ack withheld until a pop
        for (int i = 0; i < 5; i++) begin
            pk = {2'b01, 4'($urandom)};
            rx_q.push_back(pk);
            rx_send(pk, 8, acked);
            check($sformatf("t5_acked%0d", i), 32'(acked), 32'(i < 4));
        end
        check("t5_level_full", 32'(rx_level_o), 32'(4));
        rx_pop_check("t5_pop0");
        check("t5_ack5", 32'(ack_o), 32'(!ack_ph));
        ack_ph = !ack_ph;
        check("t5_level_after", 32'(rx_level_o), 32'(4));
        for (int i = 0; i < 4; i++) begin
            rx_pop_check("t5_drain");
        end
        check("t5_recv", 32'(rx_recv_o), 32'(6));
        check("t5_misroute", 32'(rx_misroute_o), 32'(0));

        // 6: misrouted header, then reset while TX waits for ack
        pk = {2'b10, 4'($urandom)};
        rx_q.push_back(pk);
        rx_send(pk, 8, acked);
        check("t6_acked", 32'(acked), 32'(1));
        check("t6_misroute", 32'(rx_misroute_o), 32'(1));
        rx_pop_check("t6_pop");
        pe.tx_valid = 1'b1;
        pe.tx_data  = 6'h0F;
        tick(1);
        pe.tx_valid = 1'b0;
        tick(2);
        check("t6_req_wait", 32'(req_o), 32'(!req_ph));
        rst = 1'b1;
        #1;
        check("t6_rst_req", 32'(req_o), 32'(0));
        check("t6_rst_data", 32'(data_o), 32'(0));
        check("t6_rst_ack", 32'(ack_o), 32'(0));
        check("t6_rst_txlvl", 32'(tx_level_o), 32'(0));
        check("t6_rst_rxlvl", 32'(rx_level_o), 32'(0));
        check("t6_rst_ready", 32'(pe.tx_ready), 32'(0));
        check("t6_rst_mis", 32'(rx_misroute_o), 32'(0));
        check("t6_rst_sent", 32'(tx_sent_o), 32'(0));
        check("t6_rst_recv", 32'(rx_recv_o), 32'(0));
        ack_i  = 1'b0;
        req_i  = 1'b0;
        req_ph = 1'b0;
        ack_ph = 1'b0;
        tx_q.delete();
        rx_q.delete();
        exp_mis = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);

        // randomized concurrent traffic on both directions
        fork
            pe_tx_proc(40);
            link_tx_proc(40);
            link_rx_proc(40);
            pe_rx_proc(40);
        join
        tick(6);
        check("rnd_tx_sent", 32'(tx_sent_o), 32'(40));
        check("rnd_rx_recv", 32'(rx_recv_o), 32'(40));
        check("rnd_tx_level", 32'(tx_level_o), 32'(0));
        check("rnd_rx_level", 32'(rx_level_o), 32'(0));
        check("rnd_misroute", 32'(rx_misroute_o), 32'(exp_mis));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
